// File: rtl/ipsl_pcie_seio_pkg.sv
// Shared encodings for the serial register interface: FSM states, opcodes
// and a width helper used to size the frame bit counter.
package ipsl_pcie_seio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10,
        ACK   = 2'b11
    } state_t;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ipsl_pcie_seio_sync.sv
// Two-flop synchroniser bringing one host-side serial line into pclk_div2.
module ipsl_pcie_seio_sync (
    input  logic pclk_div2,
    input  logic user_rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge pclk_div2 or negedge user_rst_n) begin
        if (!user_rst_n) begin
            meta_reg <= 1'b0;
            q        <= 1'b0;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/ipsl_pcie_seio_regif_v1_1.sv
// Serial register interface: decodes opcode/address/data frames from the host,
// writes or reads back a small register file and pulses an ack per transaction.
module ipsl_pcie_seio_regif_v1_1
    import ipsl_pcie_seio_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int LEGACY_NACK = 0
) (
    input  logic                       pclk_div2,
    input  logic                       user_rst_n,
    input  logic                       sedo_in,
    input  logic                       sedo_en_in,
    output logic                       sedi,
    output logic                       sedi_ack,
    output logic                       txn_err,
    output logic [NUM_REGS*DATA_W-1:0] reg_out
);

    localparam int SH_W  = ADDR_W + DATA_W;
    localparam int CNT_W = clog2(2 + ADDR_W + DATA_W + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1;

    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(2 + ADDR_W + DATA_W);
    localparam logic [CNT_W-1:0]  CNT_WR     = CNT_W'(1 + ADDR_W + DATA_W);
    localparam logic [CNT_W-1:0]  CNT_RD     = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0]  RESP_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic s_dat;
    logic s_en;

    ipsl_pcie_seio_sync u_sync_dat (
        .pclk_div2  (pclk_div2),
        .user_rst_n (user_rst_n),
        .d          (sedo_in),
        .q          (s_dat)
    );

    ipsl_pcie_seio_sync u_sync_en (
        .pclk_div2  (pclk_div2),
        .user_rst_n (user_rst_n),
        .d          (sedo_en_in),
        .q          (s_en)
    );

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [SH_W-1:0]   shreg_reg, shreg_next;
    logic              opcode_reg, opcode_next;
    logic              armed_reg, armed_next;
    logic              sedi_reg, sedi_next;
    logic              ack_reg, ack_next;
    logic              err_reg, err_next;
    logic              wr_en;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              wr_ok;
    logic              rd_ok;

    // A write frame leaves addr above the data field; a read frame leaves addr in the low bits.
    assign wr_addr = shreg_reg[DATA_W +: ADDR_W];
    assign rd_addr = shreg_reg[ADDR_W-1:0];
    assign wr_idx  = shreg_reg[DATA_W +: IDX_W];
    assign rd_idx  = shreg_reg[IDX_W-1:0];
    assign rd_word = regs[rd_idx];
    assign wr_ok   = (opcode_reg == OP_WR) && (cnt_reg == CNT_WR) && ({1'b0, wr_addr} < NUM_REGS_L);
    assign rd_ok   = (opcode_reg == OP_RD) && (cnt_reg == CNT_RD) && ({1'b0, rd_addr} < NUM_REGS_L);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        shreg_next  = shreg_reg;
        opcode_next = opcode_reg;
        armed_next  = armed_reg;
        sedi_next   = 1'b0;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        wr_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_en && armed_reg) begin
                    state_next  = SHIFT;
                    cnt_next    = CNT_W'(1);
                    opcode_next = s_dat;
                    shreg_next  = '0;
                    armed_next  = 1'b0;
                end else if (!s_en) begin
                    armed_next = 1'b1;
                end
            end
            SHIFT: begin
                if (s_en) begin
                    shreg_next = {shreg_reg[SH_W-2:0], s_dat};
                    if (cnt_reg != CNT_SAT) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else begin
                    cnt_next = '0;
                    if (LEGACY_NACK != 0) begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                    end else if (wr_ok) begin
                        wr_en      = 1'b1;
                        state_next = ACK;
                        ack_next   = 1'b1;
                    end else if (rd_ok) begin
                        // The shift register is reused to serialise the read word.
                        state_next = RESP;
                        shreg_next = {{ADDR_W{1'b0}}, rd_word};
                        sedi_next  = rd_word[DATA_W-1];
                    end else begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                        err_next   = 1'b1;
                    end
                end
            end
            RESP: begin
                shreg_next = {shreg_reg[SH_W-2:0], 1'b0};
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == RESP_LAST) begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                end else begin
                    sedi_next = shreg_reg[DATA_W-2];
                end
            end
            ACK: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk_div2 or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shreg_reg  <= '0;
            opcode_reg <= 1'b0;
            armed_reg  <= 1'b0;
            sedi_reg   <= 1'b0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            shreg_reg  <= shreg_next;
            opcode_reg <= opcode_next;
            armed_reg  <= armed_next;
            sedi_reg   <= sedi_next;
            ack_reg    <= ack_next;
            err_reg    <= err_next;
            if (wr_en) begin
                regs[wr_idx] <= shreg_reg[DATA_W-1:0];
            end
        end
    end

    assign sedi     = sedi_reg;
    assign sedi_ack = ack_reg;
    assign txn_err  = err_reg;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
        assign reg_out[gi*DATA_W +: DATA_W] = regs[gi];
    end

endmodule
